// File: rtl/four_bit_adder_subtractor.sv
// Registered WIDTH-bit two's-complement adder/subtractor built from explicit
// ripple-carry full-adder cells. Result = A + B (subtract=0) or A - B (subtract=1).
// Optional flags: define ADDSUB_FLAGS_EN to compute and register Overflow and Zero;
// without it both are tied to 0 and no flag flops exist.
module four_bit_adder_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             subtract,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  logic [WIDTH-1:0] bx_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH:0]   carry_c;

  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;

  // Ripple-carry chain: B inverted and carry-in set when subtracting.
  always_comb begin
    bx_c       = B ^ {WIDTH{subtract}};
    sum_c      = '0;
    carry_c    = '0;
    carry_c[0] = subtract;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_c[i]     = A[i] ^ bx_c[i] ^ carry_c[i];
      carry_c[i+1] = (A[i] & bx_c[i]) | (carry_c[i] & (A[i] ^ bx_c[i]));
    end
  end

  // Next-state values for the result pipeline stage.
  always_comb begin
    result_d = sum_c;
    cout_d   = carry_c[WIDTH];
  end

  // Output pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign Result = result_q;
  assign Cout   = cout_q;

`ifdef ADDSUB_FLAGS_EN
  logic overflow_q, overflow_d;
  logic zero_q,     zero_d;

  // Signed overflow from the top two carries; zero from the raw sum.
  always_comb begin
    overflow_d = carry_c[WIDTH] ^ carry_c[WIDTH-1];
    zero_d     = ~|sum_c;
  end

  // Flag pipeline register, reset to 0 alongside the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign Overflow = overflow_q;
  assign Zero     = zero_q;
`else
  assign Overflow = 1'b0;
  assign Zero     = 1'b0;
`endif

endmodule

// File: tb/tb_four_bit_adder_subtractor.sv
// Self-checking bench for four_bit_adder_subtractor: directed vector table,
// reset sequences, exhaustive sweep and random ops against an arithmetic model.
module tb_four_bit_adder_subtractor;

`ifdef ADDSUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       sub;
  logic [3:0] result;
  logic       cout, overflow, zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  four_bit_adder_subtractor #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .subtract (sub),
    .Result   (result),
    .Cout     (cout),
    .Overflow (overflow),
    .Zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic vec_t model(input int ua, input int ub, input bit s);
    vec_t v;
    int sa, sb, r, sr;
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    if (s) begin
      r      = ua - ub;
      sr     = sa - sb;
      v.cout = (ua >= ub);
    end else begin
      r      = ua + ub;
      sr     = sa + sb;
      v.cout = (r >= 16);
    end
    r      = (r + 16) % 16;
    v.a    = 4'(ua);
    v.b    = 4'(ub);
    v.sub  = s;
    v.res  = 4'(r);
    v.ovf  = FLAGS && (sr > 7 || sr < -8);
    v.zero = FLAGS && (r == 0);
    return v;
  endfunction

  task automatic check_out(input string tag, input vec_t e);
    chk4({tag, ".result"},   result,   e.res);
    chk1({tag, ".cout"},     cout,     e.cout);
    chk1({tag, ".overflow"}, overflow, e.ovf);
    chk1({tag, ".zero"},     zero,     e.zero);
  endtask

  // One operation per cycle: drive after negedge, sample 1 unit after posedge.
  task automatic apply(input vec_t e, input string tag);
    @(negedge clk);
    a   = e.a;
    b   = e.b;
    sub = e.sub;
    @(posedge clk);
    #1;
    check_out(tag, e);
  endtask

  vec_t table_v[9];
  vec_t zero_v;
  vec_t e;

  initial begin
    // {a, b, sub, res, cout, ovf(flags build), zero(flags build)}
    table_v[0] = '{4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0};
    table_v[1] = '{4'd5,  4'd3, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0};
    table_v[2] = '{4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0};
    table_v[3] = '{4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
    table_v[4] = '{4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0};
    table_v[5] = '{4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0};
    table_v[6] = '{4'd4,  4'd4, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1};
    table_v[7] = '{4'd0,  4'd1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0};
    table_v[8] = '{4'd9,  4'd0, 1'b1, 4'd9,  1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      table_v[i].ovf  = table_v[i].ovf  & FLAGS;
      table_v[i].zero = table_v[i].zero & FLAGS;
    end
    zero_v = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    // Initial reset with non-zero operands to show rst wins.
    rst = 1'b1;
    a   = 4'd15;
    b   = 4'd15;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", zero_v);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      apply(table_v[i], $sformatf("vec%0d", i));

    // Mid-stream reset: in-flight op discarded, then first op after release.
    apply(model(6, 7, 1'b0), "pre_rst");
    @(negedge clk);
    rst = 1'b1;
    a   = 4'd9;
    b   = 4'd9;
    sub = 1'b0;
    @(posedge clk);
    #1;
    check_out("mid_rst", zero_v);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    e = model(9, 9, 1'b0);
    chk4("post_rst.result_is_2", result, 4'd2);
    chk1("post_rst.cout_is_1", cout, 1'b1);
    check_out("post_rst", e);

    // Exhaustive sweep, one operation per cycle.
    for (int s = 0; s < 2; s++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          apply(model(ia, ib, s[0]), $sformatf("sweep_a%0d_b%0d_s%0d", ia, ib, s));

    // Random operations.
    for (int n = 0; n < 200; n++)
      apply(model(int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom_range(1))),
            $sformatf("rand%0d", n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
